// File: rtl/seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_pkg
// Description : Shared types and constants for the sequencer playback slice.
// Revision    : 1.0  initial release
// ============================================================================
package seq_pkg;

    localparam logic [1:0] MODE_EDIT = 2'b00;
    localparam logic [1:0] MODE_PLAY = 2'b01;

    localparam int NUM_STEPS = 8;
    localparam int NUM_SMPL  = 4;

    typedef logic [NUM_SMPL-1:0] smpl_mask_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } play_state_t;

    // Step index advances modulo NUM_STEPS; 3-bit wrap gives that for free.
    function automatic logic [2:0] next_step(input logic [2:0] cur);
        return cur + 3'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_step_player_if.sv
`default_nettype none
// ============================================================================
// Module      : seq_step_player_if
// Description : Control, pattern and status bundle between editor side and player.
// Revision    : 1.0  initial release
// ============================================================================
interface seq_step_player_if #(
    parameter int TICK_W = 24
);
    import seq_pkg::*;

    logic [1:0]        mode;
    logic              play_start;
    logic              play_stop;
    logic              tempo_up;
    logic              tempo_down;
    smpl_mask_t        seq_smpl_1;
    smpl_mask_t        seq_smpl_2;
    smpl_mask_t        seq_smpl_3;
    smpl_mask_t        seq_smpl_4;
    smpl_mask_t        seq_smpl_5;
    smpl_mask_t        seq_smpl_6;
    smpl_mask_t        seq_smpl_7;
    smpl_mask_t        seq_smpl_8;
    smpl_mask_t        trig;
    logic [2:0]        step_idx;
    logic              step_strobe;
    logic              bar_done;
    logic              playing;
    logic [TICK_W-1:0] step_ticks;

    modport master (
        output mode, play_start, play_stop, tempo_up, tempo_down,
        output seq_smpl_1, seq_smpl_2, seq_smpl_3, seq_smpl_4,
        output seq_smpl_5, seq_smpl_6, seq_smpl_7, seq_smpl_8,
        input  trig, step_idx, step_strobe, bar_done, playing, step_ticks
    );

    modport slave (
        input  mode, play_start, play_stop, tempo_up, tempo_down,
        input  seq_smpl_1, seq_smpl_2, seq_smpl_3, seq_smpl_4,
        input  seq_smpl_5, seq_smpl_6, seq_smpl_7, seq_smpl_8,
        output trig, step_idx, step_strobe, bar_done, playing, step_ticks
    );

endinterface
`default_nettype wire

// File: rtl/seq_tempo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : seq_tempo_ctrl
// Description : Holds the step period and applies clamped tempo up/down pulses.
// Revision    : 1.0  initial release
// ============================================================================
module seq_tempo_ctrl #(
    parameter int TICK_W         = 24,
    parameter int DEF_STEP_TICKS = 3_000_000,
    parameter int TEMPO_STEP     = 100_000,
    parameter int MIN_STEP_TICKS = 500_000,
    parameter int MAX_STEP_TICKS = 12_000_000
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              tempo_up,
    input  wire logic              tempo_down,
    output logic [TICK_W-1:0]      step_ticks
);

    localparam logic [TICK_W:0]   c_step_w = (TICK_W+1)'(TEMPO_STEP);
    localparam logic [TICK_W:0]   c_min_w  = (TICK_W+1)'(MIN_STEP_TICKS);
    localparam logic [TICK_W:0]   c_max_w  = (TICK_W+1)'(MAX_STEP_TICKS);
    localparam logic [TICK_W-1:0] c_step   = TICK_W'(TEMPO_STEP);
    localparam logic [TICK_W-1:0] c_min    = TICK_W'(MIN_STEP_TICKS);
    localparam logic [TICK_W-1:0] c_max    = TICK_W'(MAX_STEP_TICKS);
    localparam logic [TICK_W-1:0] c_def    = TICK_W'(DEF_STEP_TICKS);

    logic [TICK_W-1:0] r_ticks;
    logic [TICK_W:0]   w_ext;
    logic [TICK_W-1:0] w_faster;
    logic [TICK_W-1:0] w_slower;

    // Clamp decisions are made one bit wider so neither direction can wrap.
    assign w_ext    = {1'b0, r_ticks};
    assign w_faster = (w_ext >= c_min_w + c_step_w) ? (r_ticks - c_step) : c_min;
    assign w_slower = (w_ext + c_step_w > c_max_w)  ? c_max : (r_ticks + c_step);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ticks <= c_def;
        end else if (tempo_up && !tempo_down) begin
            r_ticks <= w_faster;
        end else if (tempo_down && !tempo_up) begin
            r_ticks <= w_slower;
        end
    end

    assign step_ticks = r_ticks;

endmodule
`default_nettype wire

// File: rtl/seq_step_player.sv
`default_nettype none
// ============================================================================
// Module      : seq_step_player
// Description : Walks eight step patterns at a programmable tempo, pulsing triggers.
// Revision    : 1.0  initial release
// ============================================================================
module seq_step_player
    import seq_pkg::*;
#(
    parameter int TICK_W         = 24,
    parameter int DEF_STEP_TICKS = 3_000_000,
    parameter int TEMPO_STEP     = 100_000,
    parameter int MIN_STEP_TICKS = 500_000,
    parameter int MAX_STEP_TICKS = 12_000_000
) (
    input  wire logic          clk,
    input  wire logic          rst,
    seq_step_player_if.slave   bus
);

    localparam logic [0:0] ST_IDLE = 1'(IDLE);
    localparam logic [0:0] ST_RUN  = 1'(RUN);

    logic [0:0]        r_state;
    logic [2:0]        r_step;
    logic [TICK_W-1:0] r_tick_cnt;
    smpl_mask_t        r_trig;
    logic              r_strobe;
    logic              r_bar;

    logic [TICK_W-1:0] w_step_ticks;
    logic [TICK_W:0]   w_cnt_inc;
    logic              w_boundary;
    logic              w_play_mode;
    logic              w_start;
    logic              w_exit;
    logic [2:0]        w_next_step;
    smpl_mask_t        w_pat [NUM_STEPS];

    seq_tempo_ctrl #(
        .TICK_W         (TICK_W),
        .DEF_STEP_TICKS (DEF_STEP_TICKS),
        .TEMPO_STEP     (TEMPO_STEP),
        .MIN_STEP_TICKS (MIN_STEP_TICKS),
        .MAX_STEP_TICKS (MAX_STEP_TICKS)
    ) u_tempo (
        .clk        (clk),
        .rst        (rst),
        .tempo_up   (bus.tempo_up),
        .tempo_down (bus.tempo_down),
        .step_ticks (w_step_ticks)
    );

    assign w_pat[0] = bus.seq_smpl_1;
    assign w_pat[1] = bus.seq_smpl_2;
    assign w_pat[2] = bus.seq_smpl_3;
    assign w_pat[3] = bus.seq_smpl_4;
    assign w_pat[4] = bus.seq_smpl_5;
    assign w_pat[5] = bus.seq_smpl_6;
    assign w_pat[6] = bus.seq_smpl_7;
    assign w_pat[7] = bus.seq_smpl_8;

    assign w_play_mode = (bus.mode == MODE_PLAY);
    assign w_start     = (r_state == ST_IDLE) && bus.play_start && !bus.play_stop && w_play_mode;
    assign w_exit      = (r_state == ST_RUN) && (bus.play_stop || !w_play_mode);
    assign w_next_step = next_step(r_step);

    // tick_cnt + 1 >= step_ticks, i.e. tick_cnt >= step_ticks - 1 without underflow;
    // ">=" lets a period shortened mid-step end that step right away.
    assign w_cnt_inc  = {1'b0, r_tick_cnt} + {{TICK_W{1'b0}}, 1'b1};
    assign w_boundary = (w_cnt_inc >= {1'b0, w_step_ticks});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_step     <= 3'd0;
            r_tick_cnt <= '0;
            r_trig     <= '0;
            r_strobe   <= 1'b0;
            r_bar      <= 1'b0;
        end else begin
            r_trig   <= '0;
            r_strobe <= 1'b0;
            r_bar    <= 1'b0;
            if (r_state == ST_IDLE) begin
                if (w_start) begin
                    r_state    <= ST_RUN;
                    r_step     <= 3'd0;
                    r_tick_cnt <= '0;
                    r_trig     <= w_pat[0];
                    r_strobe   <= 1'b1;
                end
            end else begin
                // Leaving RUN outranks a coincident step boundary: no trigger.
                if (w_exit) begin
                    r_state    <= ST_IDLE;
                    r_step     <= 3'd0;
                    r_tick_cnt <= '0;
                end else if (w_boundary) begin
                    r_tick_cnt <= '0;
                    r_step     <= w_next_step;
                    r_trig     <= w_pat[w_next_step];
                    r_strobe   <= 1'b1;
                    r_bar      <= (r_step == 3'd7);
                end else begin
                    r_tick_cnt <= w_cnt_inc[TICK_W-1:0];
                end
            end
        end
    end

    assign bus.trig        = r_trig;
    assign bus.step_idx    = r_step;
    assign bus.step_strobe = r_strobe;
    assign bus.bar_done    = r_bar;
    assign bus.playing     = (r_state == ST_RUN);
    assign bus.step_ticks  = w_step_ticks;

endmodule
`default_nettype wire

// File: doc/seq_step_player.md
Name: seq_step_player

Overview:
- Playback stage directly downstream of the sequence editor.
- Consumes the eight 4-bit step patterns (one enable bit per sample) and walks steps 0..7 at a programmable tempo.
- Emits one-cycle trigger pulses to the four sample voices, plus step/bar status for display.
- Active only in play mode; the editor owns edit mode.

Parameters:
- TICK_W, 24, width of tempo counter and step-period register.
- DEF_STEP_TICKS, 3_000_000, step period (clk cycles) loaded at reset.
- TEMPO_STEP, 100_000, period change per tempo_up/tempo_down pulse.
- MIN_STEP_TICKS, 500_000, lower clamp of the step period.
- MAX_STEP_TICKS, 12_000_000, upper clamp of the step period.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- mode  in  2  2'b01 = play; any other value = not play
- play_start  in  1  one-cycle pulse, begin playback
- play_stop  in  1  one-cycle pulse, end playback
- tempo_up  in  1  one-cycle pulse, shorten period (faster)
- tempo_down  in  1  one-cycle pulse, lengthen period (slower)
- seq_smpl_1..seq_smpl_8  in  4 each  step patterns; bit i = sample i
- trig  out  4  one-cycle sample trigger pulses
- step_idx  out  3  current step (0..7)
- step_strobe  out  1  pulses when a step is entered
- bar_done  out  1  pulses on wrap 7->0
- playing  out  1  high in RUN
- step_ticks  out  TICK_W  current step period

Behaviour:
- Reset (async):
  - state=IDLE, step_idx=0, tick_cnt=0, step_ticks=DEF_STEP_TICKS.
  - trig=0, step_strobe=0, bar_done=0, playing=0.
- FSM has two states, IDLE and RUN.
- IDLE -> RUN:
  - Condition: play_start=1, play_stop=0 and mode=01 in cycle N.
  - At cycle N+1: playing=1, step_idx=0, tick_cnt=0, trig=seq_smpl_1, step_strobe=1.
- RUN operation:
  - tick_cnt increments every cycle.
  - Step boundary when tick_cnt >= step_ticks-1. Use >= so a shortened period takes effect immediately.
  - At the boundary, the next cycle has: tick_cnt=0, step_idx=step_idx+1 (mod 8), trig=pattern of the new step (sampled at the boundary cycle), step_strobe=1.
  - bar_done=1 together with step_strobe when step_idx wraps 7->0.
  - First step length is exactly step_ticks cycles. Every step lasts step_ticks cycles.
- trig, step_strobe and bar_done are high for exactly one cycle. They are 0 in all other cycles.
- RUN -> IDLE:
  - Condition: play_stop=1 or mode!=01.
  - Next cycle: playing=0, step_idx=0, tick_cnt=0, trig=0.
  - No trigger is issued even if that cycle was a step boundary.
- Simultaneous play_start and play_stop: stop wins. From IDLE, stay in IDLE.
- play_start while in RUN: ignored.
- Pattern edits during RUN: take effect the next time that step is entered. No retrigger of the current step.
- Tempo control (works in any state):
  - tempo_up: step_ticks -= TEMPO_STEP, clamped at MIN_STEP_TICKS.
  - tempo_down: step_ticks += TEMPO_STEP, clamped at MAX_STEP_TICKS.
  - Both pulses in the same cycle: no change.
  - Arithmetic is done TICK_W+1 bits wide before the clamp, so there is no wrap.
- Reset mid-RUN: immediate return to reset values. Tempo returns to DEF_STEP_TICKS.

Decomposition:
- Shared package seq_pkg:
  - MODE_EDIT=2'b00, MODE_PLAY=2'b01.
  - NUM_STEPS=8, NUM_SMPL=4.
  - typedef smpl_mask_t (logic [NUM_SMPL-1:0]).
  - typedef enum play_state_t {IDLE, RUN}.
- One sub-module, seq_tempo_ctrl: holds step_ticks, applies up/down with clamping, outputs step_ticks.
- Step counter, FSM and trigger register stay in seq_step_player.

Test Plan:
Bench parameters: DEF_STEP_TICKS=4, TEMPO_STEP=1, MIN=2, MAX=6. Patterns seq_smpl_k = k[3:0] (1..8).
- Start/run: mode=01, play_start pulse at cycle 0 -> trig=1 at cycle 1, trig=2 at 5, trig=3 at 9, …, trig=8 at 29, trig=1 at 33 with bar_done=1. step_strobe at 1,5,…,33. trig=0 elsewhere.
- Stop priority: play_start and play_stop in the same cycle -> playing stays 0, no trig. play_stop at cycle 7 of a run -> cycle 8: playing=0, step_idx=0, no trig at cycle 9.
- Mode exit: mode goes 01->00 during RUN -> next cycle IDLE. play_start with mode=00 -> ignored.
- Tempo clamp: 5 tempo_up pulses -> step_ticks=2, not lower. 10 tempo_down pulses -> 6. up+down together -> unchanged. In RUN at tick_cnt=3, drop the period to 2 -> boundary on the next cycle.
- Live edit: change seq_smpl_3 to 4'hF while step 1 is playing -> trig=4'hF on entering step 2.
- Async reset asserted mid-RUN -> outputs zero immediately, step_ticks=4. After release, remains IDLE.
